// File: rtl/fp21_min_tracker.sv
// Streaming minimum tracker for FP21 candidates {sign, signed exp[7], frac[13]} grouped into packets by in_last.
// Optional macro FP21_MIN_TRACKER_NEG_REJECT_EN drops negative candidates from the search.
module fp21_min_tracker #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned EXP_W  = 7,
  localparam int unsigned FRAC_W = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     in_sign,
  input  logic signed [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0]        in_frac,
  input  logic [ID_W-1:0]          in_id,
  output logic                     out_valid,
  output logic                     out_hit,
  output logic                     out_sign,
  output logic [EXP_W-1:0]         out_exp,
  output logic [FRAC_W-1:0]        out_frac,
  output logic [ID_W-1:0]          out_id,
  output logic [CNT_W-1:0]         out_count
);

  // Stage S1: registered candidate
  logic                    s1_valid_q, s1_last_q, s1_sign_q;
  logic signed [EXP_W-1:0] s1_exp_q;
  logic [FRAC_W-1:0]       s1_frac_q;
  logic [ID_W-1:0]         s1_id_q;

  // Stage S2: running best of the open packet
  logic                    hit_q, hit_d;
  logic                    best_sign_q, best_sign_d;
  logic signed [EXP_W-1:0] best_exp_q, best_exp_d;
  logic [FRAC_W-1:0]       best_frac_q, best_frac_d;
  logic [ID_W-1:0]         best_id_q, best_id_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Closed-packet result, one cycle ahead of the outputs
  logic                    res_valid_q, res_valid_d;
  logic                    res_hit_q, res_hit_d;
  logic                    res_sign_q, res_sign_d;
  logic signed [EXP_W-1:0] res_exp_q, res_exp_d;
  logic [FRAC_W-1:0]       res_frac_q, res_frac_d;
  logic [ID_W-1:0]         res_id_q, res_id_d;
  logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;

  logic accept_c, take_c, close_c;
  logic fold_hit, fold_sign;
  logic signed [EXP_W-1:0] fold_exp;
  logic [FRAC_W-1:0]       fold_frac;
  logic [ID_W-1:0]         fold_id;
  logic [CNT_W-1:0]        fold_cnt;

  // Strict less-than; equal encodings are never "less", so ties keep the incumbent
  function automatic logic fp_lt(input logic sa, input logic signed [EXP_W-1:0] ea,
                                 input logic [FRAC_W-1:0] fa, input logic sb,
                                 input logic signed [EXP_W-1:0] eb, input logic [FRAC_W-1:0] fb);
    logic mag_lt;
    mag_lt = (ea < eb) | ((ea == eb) & (fa < fb));
    if (sa != sb)                    fp_lt = sa;
    else if ((ea == eb) && (fa == fb)) fp_lt = 1'b0;
    else                             fp_lt = mag_lt ^ (sa & sb);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_frac_q  <= '0;
      s1_id_q    <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_last_q <= in_last;
        s1_sign_q <= in_sign;
        s1_exp_q  <= in_exp;
        s1_frac_q <= in_frac;
        s1_id_q   <= in_id;
      end
    end
  end

`ifdef FP21_MIN_TRACKER_NEG_REJECT_EN
  assign accept_c = s1_valid_q & ~s1_sign_q;
`else
  assign accept_c = s1_valid_q;
`endif
  assign close_c = s1_valid_q & s1_last_q;
  assign take_c  = accept_c & (~hit_q | fp_lt(s1_sign_q, s1_exp_q, s1_frac_q,
                                               best_sign_q, best_exp_q, best_frac_q));

  always_comb begin
    fold_hit  = hit_q | accept_c;
    fold_sign = take_c ? s1_sign_q : best_sign_q;
    fold_exp  = take_c ? s1_exp_q  : best_exp_q;
    fold_frac = take_c ? s1_frac_q : best_frac_q;
    fold_id   = take_c ? s1_id_q   : best_id_q;
    fold_cnt  = cnt_q;
    if (accept_c && (cnt_q != {CNT_W{1'b1}})) fold_cnt = cnt_q + CNT_W'(1);

    hit_d       = fold_hit;
    best_sign_d = fold_sign;
    best_exp_d  = fold_exp;
    best_frac_d = fold_frac;
    best_id_d   = fold_id;
    cnt_d       = fold_cnt;
    res_valid_d = close_c;
    res_hit_d   = res_hit_q;
    res_sign_d  = res_sign_q;
    res_exp_d   = res_exp_q;
    res_frac_d  = res_frac_q;
    res_id_d    = res_id_q;
    res_cnt_d   = res_cnt_q;
    if (close_c) begin
      res_hit_d   = fold_hit;
      res_sign_d  = fold_sign;
      res_exp_d   = fold_exp;
      res_frac_d  = fold_frac;
      res_id_d    = fold_id;
      res_cnt_d   = fold_cnt;
      hit_d       = 1'b0;
      best_sign_d = 1'b0;
      best_exp_d  = '0;
      best_frac_d = '0;
      best_id_d   = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      best_sign_q <= 1'b0;
      best_exp_q  <= '0;
      best_frac_q <= '0;
      best_id_q   <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_sign_q  <= 1'b0;
      res_exp_q   <= '0;
      res_frac_q  <= '0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
    end else begin
      hit_q       <= hit_d;
      best_sign_q <= best_sign_d;
      best_exp_q  <= best_exp_d;
      best_frac_q <= best_frac_d;
      best_id_q   <= best_id_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_sign_q  <= res_sign_d;
      res_exp_q   <= res_exp_d;
      res_frac_q  <= res_frac_d;
      res_id_q    <= res_id_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  // Output stage: pulse valid, hold payload between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_frac  <= '0;
      out_id    <= '0;
      out_count <= '0;
    end else begin
      out_valid <= res_valid_q;
      if (res_valid_q) begin
        out_hit   <= res_hit_q;
        out_sign  <= res_sign_q;
        out_exp   <= res_exp_q;
        out_frac  <= res_frac_q;
        out_id    <= res_id_q;
        out_count <= res_cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_fp21_min_tracker.sv
// Scoreboard bench for fp21_min_tracker: real-valued reference model, directed and random packets.
module tb_fp21_min_tracker;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EXP_W  = 7;
  localparam int unsigned FRAC_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, in_sign = 1'b0;
  logic signed [EXP_W-1:0] in_exp = '0;
  logic [FRAC_W-1:0] in_frac = '0;
  logic [ID_W-1:0] in_id = '0;
  logic out_valid, out_hit, out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [FRAC_W-1:0] out_frac;
  logic [ID_W-1:0] out_id;
  logic [CNT_W-1:0] out_count;

  fp21_min_tracker #(.ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac), .in_id(in_id),
    .out_valid(out_valid), .out_hit(out_hit), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac), .out_id(out_id), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             s;
    int               e;
    int               f;
    logic [ID_W-1:0]  id;
  } cand_t;

  typedef struct {
    logic             hit;
    logic             s;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } res_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  cand_t pkt[$];
  res_t  sb[$];
  res_t  hold_ref = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real to_real(input cand_t c);
    real r;
    r = 1.0 + real'(c.f) / 8192.0;
    if (c.e >= 0) for (int i = 0; i < c.e; i++) r = r * 2.0;
    else          for (int i = 0; i < -c.e; i++) r = r / 2.0;
    return c.s ? -r : r;
  endfunction

  // Reference: smallest real value, first occurrence wins; count saturates
  function automatic res_t model_close(input int exp_cyc);
    res_t r;
    cand_t best;
    r = '{default: '0};
    r.cyc = exp_cyc;
    best = '{default: '0};
    foreach (pkt[i]) begin
      if (i == 0 || to_real(pkt[i]) < to_real(best)) best = pkt[i];
    end
    if (pkt.size() > 0) begin
      r.hit = 1'b1;
      r.s   = best.s;
      r.e   = EXP_W'(best.e);
      r.f   = FRAC_W'(best.f);
      r.id  = best.id;
      r.cnt = (pkt.size() > 255) ? CNT_W'(255) : CNT_W'(pkt.size());
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic l, input logic s,
                       input int e, input int f, input int id);
    cand_t c;
    @(posedge clk);
    #1;
    in_valid = v; in_last = l; in_sign = s;
    in_exp = EXP_W'(e); in_frac = FRAC_W'(f); in_id = ID_W'(id);
    c = '{s: s, e: e, f: f, id: ID_W'(id)};
    if (v) begin
`ifdef FP21_MIN_TRACKER_NEG_REJECT_EN
      if (!s) pkt.push_back(c);
`else
      pkt.push_back(c);
`endif
      if (l) begin
        sb.push_back(model_close(cyc + 3));
        pkt.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b0;
    pkt.delete();
    hold_ref = '{default: '0};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop on each pulse, otherwise check that the payload is held
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      res_t x;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d id=%0d", cyc, out_id);
      end else begin
        x = sb.pop_front();
        if ({out_hit, out_sign, out_exp, out_frac, out_id, out_count} !==
            {x.hit, x.s, x.e, x.f, x.id, x.cnt} || cyc != x.cyc) begin
          failures++;
          $display("FAIL result cyc got=%0d want=%0d hit %b/%b sign %b/%b exp %0h/%0h frac %0h/%0h id %0d/%0d cnt %0d/%0d",
                   cyc, x.cyc, out_hit, x.hit, out_sign, x.s, out_exp, x.e, out_frac, x.f,
                   out_id, x.id, out_count, x.cnt);
        end
        hold_ref = x;
      end
    end else if (rst_n) begin
      checks++;
      if ({out_hit, out_sign, out_exp, out_frac, out_id, out_count} !==
          {hold_ref.hit, hold_ref.s, hold_ref.e, hold_ref.f, hold_ref.id, hold_ref.cnt}) begin
        failures++;
        $display("FAIL hold cyc=%0d got id=%0d cnt=%0d want id=%0d cnt=%0d",
                 cyc, out_id, out_count, hold_ref.id, hold_ref.cnt);
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_hit, out_sign, out_exp, out_frac, out_id, out_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%0h want=0",
               {out_valid, out_hit, out_sign, out_exp, out_frac, out_id, out_count});
    end
    rst_n = 1'b1;

    // 2.0 id3, 0.5 id7, 1.0 id9 last
    drive(1, 0, 0, 1, 0, 3);
    drive(1, 0, 0, -1, 0, 7);
    drive(1, 1, 0, 0, 0, 9);
    // tie keeps earlier
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 2);
    // -3.0 id4, 1.0 id5 last
    drive(1, 0, 1, 1, 4096, 4);
    drive(1, 1, 0, 0, 0, 5);
    // lone -1.0 last
    drive(1, 1, 1, 0, 0, 11);
    // lone last without valid is ignored
    drive(0, 1, 0, 0, 0, 99);
    // four single-candidate packets back to back
    for (int i = 0; i < 4; i++) drive(1, 1, 0, i, 100, 20 + i);
    // negative-only ordering: -1.0 vs -2.0 vs -2.0
    drive(1, 0, 1, 0, 0, 30);
    drive(1, 0, 1, 1, 0, 31);
    drive(1, 1, 1, 1, 0, 32);
    idle(6);

    // abort mid-packet, then a fresh packet
    drive(1, 0, 0, 0, 0, 40);
    drive(1, 0, 0, 1, 0, 41);
    do_reset();
    drive(1, 1, 0, 2, 0, 6);
    idle(6);

    // counter saturation
    for (int i = 0; i < 300; i++) drive(1, (i == 299), 0, 3 - (i % 5), 8191 - i, i);

    // random traffic, including lone lasts
    for (int i = 0; i < 600; i++) begin
      logic v, l;
      int fsel;
      v = ($urandom % 4) != 0;
      l = v ? (($urandom % 4) == 0) : (($urandom % 8) == 0);
      fsel = $urandom % 3;
      drive(v, l, 1'($urandom % 2), int'($urandom_range(0, 4)) - 2,
            (fsel == 0) ? 0 : ((fsel == 1) ? 4096 : 8191), int'($urandom % 256));
    end
    drive(1, 1, 0, 0, 0, 77);
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp21_min_tracker.md
FP21_MIN_TRACKER -- requirements
Module: fp21_min_tracker

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, giving the candidate identifier width.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the accepted-candidate counter width.
REQ-003 Clock and reset SHALL be: clk  in  1  single clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 Input ports SHALL be: in_valid  in  1  candidate present this cycle.
REQ-005 Input ports SHALL also be: in_last  in  1  candidate closes the packet.
REQ-006 Candidate value ports SHALL be: in_sign  in  1; in_exp  in  `exp+1  signed; in_frac  in  `frac+1.
REQ-007 Candidate ID port SHALL be: in_id  in  ID_W  candidate identifier.
REQ-008 Handshake output SHALL be: out_valid  out  1  one-cycle result pulse.
REQ-009 Hit output SHALL be: out_hit  out  1  packet held at least one accepted candidate.
REQ-010 Result value outputs SHALL be: out_sign  out  1; out_exp  out  `exp+1; out_frac  out  `frac+1  minimum value.
REQ-011 Result ID output SHALL be: out_id  out  ID_W  ID of the minimum.
REQ-012 Count output SHALL be: out_count  out  CNT_W  accepted candidates in packet, saturating.

Function
REQ-013 The block SHALL always accept input; there is no backpressure, and downstream SHALL take out_* on the out_valid cycle.
REQ-014 Stage S1 SHALL register in_* when in_valid=1; S1 valid SHALL clear when in_valid=0.
REQ-015 Stage S2 SHALL fold S1 into best {sign,exp,frac,id}, hit flag, and counter on the next edge.
REQ-016 Ordering rule: a<b iff sign_a!=sign_b ? sign_a : ((exp_a<exp_b signed) | (exp_a==exp_b & frac_a<frac_b)) XOR (sign_a&sign_b), with the exact-equal fields case forced to false.
REQ-017 S1 SHALL replace best when hit flag=0, or when S1 < best; ties SHALL keep the earlier candidate.
REQ-018 Each accepted candidate SHALL increment the counter, which saturates at 2^CNT_W-1.
REQ-019 When S1 carries last, out_* SHALL present the post-fold best, flag, and count; out_valid=1 SHALL be asserted for exactly that one cycle.
REQ-020 Latency SHALL be: a last candidate sampled at edge E SHALL produce out_valid high between edges E+2 and E+3.
REQ-021 In the same fold, best, hit flag, and counter SHALL clear, so the next cycle's candidate starts a new packet.
REQ-022 Back-to-back packets SHALL be supported, including single-candidate packets on consecutive cycles.
REQ-023 A last with no accepted candidate SHALL output out_hit=0 and value, id, and count fields of 0.
REQ-024 A lone in_last without in_valid SHALL be ignored.
REQ-025 out_* SHALL hold their values between out_valid pulses.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear S1, best, hit flag, counter, and all outputs to 0.
REQ-027 A partial packet in flight at reset SHALL be discarded with no out_valid.
REQ-028 The first candidate after reset release SHALL start a new packet.

Configuration
REQ-029 Macro FP21_MIN_TRACKER_NEG_REJECT_EN SHALL control rejection of negative candidates.
REQ-030 With FP21_MIN_TRACKER_NEG_REJECT_EN defined, candidates with sign=1 SHALL be rejected (not counted, never best, except in_last still closes the packet); +0 SHALL be accepted.
REQ-031 Without the macro, all valid candidates SHALL be accepted and negative values SHALL participate in REQ-016 ordering.

Verification
REQ-032 Packet {2.0 id3, 0.5 id7, 1.0 id9 last} on consecutive cycles SHALL yield one out_valid 2 cycles after the last, with value=0.5, out_id=7, count=3, hit=1.
REQ-033 Packet {1.0 id1, 1.0 id2 last} SHALL yield out_id=1 (tie keeps earlier).
REQ-034 Without the macro, {-3.0 id4, 1.0 id5 last} SHALL yield out_id=4, value -3.0; with the macro, SHALL yield out_id=5, count=1.
REQ-035 With the macro, {-1.0 last} SHALL yield out_hit=0, count=0, value 0, id 0.
REQ-036 Four single-candidate last packets on consecutive cycles SHALL yield four consecutive out_valid pulses, each with its own id and count=1.
REQ-037 Reset asserted mid-packet after 2 candidates, then {4.0 id6 last}, SHALL yield only out_id=6, count=1, with no pulse for the aborted packet.
